// File: rtl/kftvga_text_pkg.sv
// Shared types and constants for the 80x60 text writer: command opcodes,
// engine states, screen geometry and the control codes the writer interprets.
package kftvga_text_pkg;

    localparam int COLUMNS = 80;
    localparam int ROWS    = 60;
    localparam int COL_W   = 7;
    localparam int ROW_W   = 6;
    localparam int ADDR_W  = 13;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLUMNS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    localparam logic [7:0] CLEAR_CHAR = 8'h20;
    localparam logic [7:0] RESET_ATTR = 8'h07;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_BS    = 8'h08;

    typedef enum logic [1:0] {
        OP_PUT          = 2'd0,
        OP_SET_CURSOR   = 2'd1,
        OP_SET_ATTR     = 2'd2,
        OP_CLEAR_SCREEN = 2'd3
    } cmd_op_t;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        CLEAR_ROW    = 2'd1,
        CLEAR_SCREEN = 2'd2
    } state_t;

endpackage

// File: rtl/kftvga_text_writer_if.sv
// Command stream plus VRAM write port of the text writer.
// master = host side issuing commands, slave = the writer producing VRAM writes.
interface kftvga_text_writer_if;
    import kftvga_text_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    cmd_op_t             cmd_op;
    logic [15:0]         cmd_data;
    logic                vram_write_enable;
    logic [ADDR_W-1:0]   vram_write_address;
    logic [7:0]          vram_write_char;
    logic [7:0]          vram_write_color;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, vram_write_enable, vram_write_address,
               vram_write_char, vram_write_color
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, vram_write_enable, vram_write_address,
               vram_write_char, vram_write_color
    );

endinterface

// File: rtl/kftvga_cell_address.sv
// Purpose: maps (row, col) to the linear VRAM cell index row*80+col.
// Latency: combinational. Backpressure: none.
module kftvga_cell_address
    import kftvga_text_pkg::*;
(
    input  logic [ROW_W-1:0]  row,
    input  logic [COL_W-1:0]  col,
    output logic [ADDR_W-1:0] addr
);

    // row*80 as row*16 + row*64, so no multiplier is needed
    assign addr = {3'b000, row, 4'b0000} + {1'b0, row, 6'b000000} + {6'b000000, col};

endmodule

// File: rtl/kftvga_text_writer.sv
// Purpose: text engine turning put/cursor/attr/clear commands into VRAM writes.
// Latency: 1 cycle command-to-write. Backpressure: cmd_ready low while a row or screen clear runs.
module kftvga_text_writer
    import kftvga_text_pkg::*;
(
    input  logic              video_clock,
    input  logic              reset,
    kftvga_text_writer_if.slave port,
    output logic [COL_W-1:0]  cursor_col,
    output logic [ROW_W-1:0]  cursor_row,
    output logic              busy
);

    state_t             state;
    logic [7:0]         attr;
    logic [COL_W-1:0]   clr_col;
    logic [ROW_W-1:0]   clr_row;
    logic               clr_done;

    logic               accept;
    logic               is_put;
    logic [7:0]         put_char;
    logic               put_print;
    logic               line_advance;
    logic               clr_last;
    logic [COL_W-1:0]   set_col;
    logic [ROW_W-1:0]   set_row;
    logic [COL_W-1:0]   addr_col;
    logic [ROW_W-1:0]   addr_row;
    logic [ADDR_W-1:0]  cell_addr;

    assign port.cmd_ready = (state == IDLE);
    assign busy           = ~port.cmd_ready;
    assign accept         = port.cmd_valid && port.cmd_ready;

    assign is_put    = (port.cmd_op == OP_PUT);
    assign put_char  = port.cmd_data[7:0];
    assign put_print = (put_char != CHAR_CR) && (put_char != CHAR_LF) && (put_char != CHAR_BS);

    // LF, or a printable put in the last column, moves the cursor down a row
    assign line_advance = accept && is_put &&
                          ((put_char == CHAR_LF) || (put_print && (cursor_col == LAST_COL)));

    assign clr_last = (clr_col == LAST_COL) && ((state == CLEAR_ROW) || (clr_row == LAST_ROW));

    assign set_col = (port.cmd_data[6:0] > LAST_COL) ? LAST_COL : port.cmd_data[6:0];
    assign set_row = (port.cmd_data[13:8] > LAST_ROW) ? LAST_ROW : port.cmd_data[13:8];

    // One address generator serves both the cursor write and the clear sweep
    assign addr_col = (state == IDLE) ? cursor_col : clr_col;
    assign addr_row = (state == IDLE) ? cursor_row : clr_row;

    kftvga_cell_address u_cell_address (
        .row  (addr_row),
        .col  (addr_col),
        .addr (cell_addr)
    );

    always_ff @(negedge video_clock or posedge reset) begin
        if (reset) begin
            state                   <= IDLE;
            attr                    <= RESET_ATTR;
            cursor_col              <= '0;
            cursor_row              <= '0;
            clr_col                 <= '0;
            clr_row                 <= '0;
            clr_done                <= 1'b0;
            port.vram_write_enable  <= 1'b0;
            port.vram_write_address <= '0;
            port.vram_write_char    <= 8'h00;
            port.vram_write_color   <= 8'h00;
        end else begin
            port.vram_write_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (port.cmd_op)
                            OP_PUT: begin
                                if (put_char == CHAR_CR) begin
                                    cursor_col <= '0;
                                end else if (put_char == CHAR_BS) begin
                                    if (cursor_col != '0) cursor_col <= cursor_col - 7'd1;
                                end else if (put_char != CHAR_LF) begin
                                    port.vram_write_enable  <= 1'b1;
                                    port.vram_write_address <= cell_addr;
                                    port.vram_write_char    <= put_char;
                                    port.vram_write_color   <= attr;
                                    cursor_col <= (cursor_col == LAST_COL) ? '0 : cursor_col + 7'd1;
                                end
                            end
                            OP_SET_CURSOR: begin
                                cursor_col <= set_col;
                                cursor_row <= set_row;
                            end
                            OP_SET_ATTR: begin
                                attr <= port.cmd_data[7:0];
                            end
                            OP_CLEAR_SCREEN: begin
                                // cell 0 is written on accept; the sweep resumes at cell 1
                                port.vram_write_enable  <= 1'b1;
                                port.vram_write_address <= '0;
                                port.vram_write_char    <= CLEAR_CHAR;
                                port.vram_write_color   <= attr;
                                cursor_col <= '0;
                                cursor_row <= '0;
                                clr_col    <= 7'd1;
                                clr_row    <= '0;
                                clr_done   <= 1'b0;
                                state      <= CLEAR_SCREEN;
                            end
                            default: ;
                        endcase

                        if (line_advance) begin
                            if (cursor_row == LAST_ROW) begin
                                cursor_row <= '0;
                                clr_col    <= '0;
                                clr_row    <= '0;
                                clr_done   <= 1'b0;
                                state      <= CLEAR_ROW;
                            end else begin
                                cursor_row <= cursor_row + 6'd1;
                            end
                        end
                    end
                end

                CLEAR_ROW, CLEAR_SCREEN: begin
                    // the cycle after the final write still holds off new commands
                    if (clr_done) begin
                        state <= IDLE;
                    end else begin
                        port.vram_write_enable  <= 1'b1;
                        port.vram_write_address <= cell_addr;
                        port.vram_write_char    <= CLEAR_CHAR;
                        port.vram_write_color   <= attr;
                        if (clr_last) begin
                            clr_done <= 1'b1;
                        end else if (clr_col == LAST_COL) begin
                            clr_col <= '0;
                            clr_row <= clr_row + 6'd1;
                        end else begin
                            clr_col <= clr_col + 7'd1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kftvga_text_writer.sv
// Scoreboarded bench for kftvga_text_writer: directed edge cases plus random
// command streams checked against a cursor/attribute model of the screen.
module tb_kftvga_text_writer;
    import kftvga_text_pkg::*;

    logic       video_clock = 1'b0;
    logic       reset;
    logic [6:0] cursor_col;
    logic [5:0] cursor_row;
    logic       busy;

    kftvga_text_writer_if bus ();

    kftvga_text_writer dut (
        .video_clock (video_clock),
        .reset       (reset),
        .port        (bus.slave),
        .cursor_col  (cursor_col),
        .cursor_row  (cursor_row),
        .busy        (busy)
    );

    always #20 video_clock = ~video_clock;

    typedef struct {
        int addr;
        int ch;
        int color;
    } wr_t;

    wr_t exp_q[$];
    int  busy_q[$];
    int  total = 0;
    int  bad   = 0;
    int  m_col, m_row, m_attr;

    task automatic chk(string name, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic push_wr(int addr, int ch, int color);
        wr_t w;
        w.addr = addr; w.ch = ch; w.color = color;
        exp_q.push_back(w);
    endtask

    task automatic newline(bit from_put);
        if (m_row == ROWS - 1) begin
            m_row = 0;
            for (int c = 0; c < COLUMNS; c++) push_wr(c, 'h20, m_attr);
            busy_q.push_back(from_put ? COLUMNS + 1 : -1);
        end else begin
            m_row++;
        end
    endtask

    task automatic model_accept(int op, int data);
        int ch, c, r;
        ch = data & 'hFF;
        case (op)
            0: begin
                if (ch == 'h0D) m_col = 0;
                else if (ch == 'h0A) newline(1'b0);
                else if (ch == 'h08) begin
                    if (m_col > 0) m_col--;
                end else begin
                    push_wr(m_row * COLUMNS + m_col, ch, m_attr);
                    m_col++;
                    if (m_col == COLUMNS) begin
                        m_col = 0;
                        newline(1'b1);
                    end
                end
            end
            1: begin
                c = data & 'h7F;
                r = (data >> 8) & 'h3F;
                m_col = (c > COLUMNS - 1) ? COLUMNS - 1 : c;
                m_row = (r > ROWS - 1) ? ROWS - 1 : r;
            end
            2: m_attr = ch;
            default: begin
                for (int a = 0; a < COLUMNS * ROWS; a++) push_wr(a, 'h20, m_attr);
                m_col = 0;
                m_row = 0;
                busy_q.push_back(COLUMNS * ROWS);
            end
        endcase
    endtask

    // ---------------- monitor ----------------
    int  busy_cnt = 0;
    wr_t mon_e;
    int  mon_b;

    always @(posedge video_clock) begin
        if (reset) begin
            busy_cnt = 0;
        end else begin
            if (bus.vram_write_enable) begin
                chk("write_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", int'(bus.vram_write_address), mon_e.addr);
                    chk("wr_char", int'(bus.vram_write_char), mon_e.ch);
                    chk("wr_color", int'(bus.vram_write_color), mon_e.color);
                end
            end
            if (!bus.cmd_ready) begin
                busy_cnt++;
            end else if (busy_cnt > 0) begin
                chk("busy_expected", int'(busy_q.size() > 0), 1);
                if (busy_q.size() > 0) begin
                    mon_b = busy_q.pop_front();
                    if (mon_b >= 0) chk("busy_len", busy_cnt, mon_b);
                end
                busy_cnt = 0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(int op, int data);
        int n = 0;
        @(posedge video_clock);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = cmd_op_t'(op);
        bus.cmd_data  = 16'(data);
        #1;
        while (!bus.cmd_ready && n < 6000) begin
            @(posedge video_clock);
            #1;
            n++;
        end
        chk("accept_in_time", int'(bus.cmd_ready), 1);
        if (!bus.cmd_ready) begin
            bus.cmd_valid = 1'b0;
            return;
        end
        model_accept(op, data);
        @(negedge video_clock);
        #1;
        chk("cursor_col", int'(cursor_col), m_col);
        chk("cursor_row", int'(cursor_row), m_row);
    endtask

    task automatic idle();
        @(posedge video_clock);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !bus.cmd_ready) && n < 20000) begin
            @(posedge video_clock);
            #1;
            n++;
        end
        chk("drain_pending_writes", int'(exp_q.size()), 0);
        chk("drain_ready", int'(bus.cmd_ready), 1);
    endtask

    task automatic check_reset_state(string tag);
        chk({tag, "_we"}, int'(bus.vram_write_enable), 0);
        chk({tag, "_ready"}, int'(bus.cmd_ready), 1);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_col"}, int'(cursor_col), 0);
        chk({tag, "_row"}, int'(cursor_row), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int op, data, sel, n;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_PUT;
        bus.cmd_data  = 16'h0000;
        reset  = 1'b1;
        m_col  = 0;
        m_row  = 0;
        m_attr = 'h07;

        repeat (3) @(posedge video_clock);
        #1;
        check_reset_state("reset");
        chk("reset_addr", int'(bus.vram_write_address), 0);
        chk("reset_char", int'(bus.vram_write_char), 0);
        chk("reset_color", int'(bus.vram_write_color), 0);
        @(posedge video_clock);
        reset = 1'b0;

        // 'A' at home with default attribute, visible one cycle after accept
        send(0, 'h41);
        chk("put_latency_we", int'(bus.vram_write_enable), 1);
        chk("put_latency_addr", int'(bus.vram_write_address), 0);
        idle();
        drain();

        // end-of-line wrap onto the next row
        send(1, (2 << 8) | 79);
        send(0, 'h78);
        idle();
        drain();

        // LF on the bottom row wraps to row 0 and clears it
        send(1, (59 << 8) | 5);
        send(0, 'h0A);
        chk("lf_no_write", int'(bus.vram_write_enable), 0);
        idle();
        drain();

        // printable put in the bottom-right cell: char write then row clear, 81 busy cycles
        send(1, (59 << 8) | 79);
        send(0, 'h5A);
        idle();
        drain();

        // back-to-back puts
        for (int i = 0; i < 6; i++) send(0, 'h30 + i);
        idle();
        drain();

        // full clear with a new attribute
        send(2, 'h1F);
        send(3, 0);
        idle();
        drain();

        // cursor clamping and BS at column 0
        send(1, (63 << 8) | 100);
        send(1, (10 << 8) | 0);
        send(0, 'h08);
        chk("bs_no_write", int'(bus.vram_write_enable), 0);
        idle();
        drain();

        // random command stream, mostly puts, no full clears
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 60) begin
                op = 0; data = $urandom_range(0, 255);
            end else if (sel < 68) begin
                op = 0; data = 'h0D;
            end else if (sel < 78) begin
                op = 0; data = 'h0A;
            end else if (sel < 83) begin
                op = 0; data = 'h08;
            end else if (sel < 94) begin
                op = 1;
                data = ($urandom_range(50, 63) << 8) | $urandom_range(70, 127);
                if ($urandom_range(0, 3) == 0) data = $urandom & 'hFFFF;
            end else begin
                op = 2; data = $urandom_range(0, 255);
            end
            send(op, data);
            if ($urandom_range(0, 7) == 0) idle();
        end
        idle();
        drain();

        // reset in the middle of a full-screen clear
        send(2, 'h2C);
        send(3, 0);
        idle();
        n = 0;
        while (bus.vram_write_address != 13'd1000 && n < 3000) begin
            @(posedge video_clock);
            n++;
        end
        chk("reached_addr_1000", int'(bus.vram_write_address), 1000);
        #5;
        reset = 1'b1;
        exp_q.delete();
        busy_q.delete();
        m_col  = 0;
        m_row  = 0;
        m_attr = 'h07;
        #1;
        check_reset_state("abort");
        repeat (2) @(posedge video_clock);
        reset = 1'b0;
        repeat (30) @(posedge video_clock);
        #1;
        chk("abort_stays_idle", int'(bus.cmd_ready), 1);

        // attribute is back to its reset value
        send(0, 'h42);
        idle();
        drain();

        chk("leftover_writes", int'(exp_q.size()), 0);
        chk("leftover_busy", int'(busy_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
